// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings and master-port state type
//
// Purpose: HTRANS/HBURST/HRESP codes, the master-port state enum and the
// SEQ->NONSEQ/INCR rewrite helpers used when a burst beat is held back.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_INCR = 3'b001;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA
  } port_state_e;

  // A held SEQ beat is no longer contiguous with its predecessor on the
  // downstream bus, so it restarts as an undefined-length INCR burst.
  function automatic logic [1:0] held_htrans(input logic [1:0] htrans);
    return (htrans == HTRANS_SEQ) ? HTRANS_NONSEQ : htrans;
  endfunction

  function automatic logic [2:0] held_hburst(input logic [1:0] htrans,
                                             input logic [2:0] hburst);
    return (htrans == HTRANS_SEQ) ? HBURST_INCR : hburst;
  endfunction

endpackage

// File: rtl/ahb_addr_hold.sv
// rtl/ahb_addr_hold.sv - address-phase holding register for a stalled master
//
// Purpose: captures one master address phase when the arbiter does not
// accept it, rewriting a SEQ beat to NONSEQ/INCR.
// Ports:
//   HCLK, HRESET      clock, asynchronous active-high reset (clears register)
//   load              capture enable
//   d_*               master address-phase fields
//   q_*               held address-phase fields
module ahb_addr_hold
  import ahb_pkg::*;
#(
  parameter int HADDR_W = 32
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               load,
  input  logic [1:0]         d_htrans,
  input  logic               d_hwrite,
  input  logic [2:0]         d_hsize,
  input  logic [2:0]         d_hburst,
  input  logic [3:0]         d_hprot,
  input  logic               d_hmastlock,
  input  logic [HADDR_W-1:0] d_haddr,
  output logic [1:0]         q_htrans,
  output logic               q_hwrite,
  output logic [2:0]         q_hsize,
  output logic [2:0]         q_hburst,
  output logic [3:0]         q_hprot,
  output logic               q_hmastlock,
  output logic [HADDR_W-1:0] q_haddr
);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      q_htrans    <= HTRANS_IDLE;
      q_hwrite    <= 1'b0;
      q_hsize     <= '0;
      q_hburst    <= '0;
      q_hprot     <= '0;
      q_hmastlock <= 1'b0;
      q_haddr     <= '0;
    end else if (load) begin
      q_htrans    <= held_htrans(d_htrans);
      q_hwrite    <= d_hwrite;
      q_hsize     <= d_hsize;
      q_hburst    <= held_hburst(d_htrans, d_hburst);
      q_hprot     <= d_hprot;
      q_hmastlock <= d_hmastlock;
      q_haddr     <= d_haddr;
    end
  end

endmodule

// File: rtl/ahb_mst_port.sv
// rtl/ahb_mst_port.sv - per-master AHB matrix input stage ahead of the arbiter
//
// Purpose: raises an arbitration request for each new master transfer,
// holds the address phase (stretching the master) while the arbiter is busy,
// and returns the downstream data-phase response once the transfer is issued.
// Ports:
//   HCLK, HRESET                 clock, asynchronous active-high reset
//   M_*                          master-side address/data phase and response
//   ARB_REQ, ARB_REQ_ACK         arbiter request / same-cycle acceptance
//   ARB_PRIORITY_LOCK            freeze round-robin pointers for locked xfers
//   S_*                          address/data toward the matrix and response
module ahb_mst_port
  import ahb_pkg::*;
#(
  parameter int HADDR_W = 32,
  parameter int HDATA_W = 32
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               M_HSEL,
  input  logic [1:0]         M_HTRANS,
  input  logic               M_HWRITE,
  input  logic [2:0]         M_HSIZE,
  input  logic [2:0]         M_HBURST,
  input  logic [3:0]         M_HPROT,
  input  logic               M_HMASTLOCK,
  input  logic [HADDR_W-1:0] M_HADDR,
  input  logic [HDATA_W-1:0] M_HWDATA,
  input  logic               M_HREADY,
  output logic               M_HREADYOUT,
  output logic [HDATA_W-1:0] M_HRDATA,
  output logic               M_HRESP,
  output logic               ARB_REQ,
  input  logic               ARB_REQ_ACK,
  output logic               ARB_PRIORITY_LOCK,
  output logic [1:0]         S_HTRANS,
  output logic               S_HWRITE,
  output logic [2:0]         S_HSIZE,
  output logic [2:0]         S_HBURST,
  output logic [3:0]         S_HPROT,
  output logic               S_HMASTLOCK,
  output logic [HADDR_W-1:0] S_HADDR,
  output logic [HDATA_W-1:0] S_HWDATA,
  input  logic               S_HREADY,
  input  logic [HDATA_W-1:0] S_HRDATA,
  input  logic               S_HRESP
);

  port_state_e state, state_next;

  logic               new_xfer;
  logic               hold_valid;
  logic               can_start;
  logic               hold_load;
  logic [1:0]         h_htrans;
  logic               h_hwrite;
  logic [2:0]         h_hsize;
  logic [2:0]         h_hburst;
  logic [3:0]         h_hprot;
  logic               h_hmastlock;
  logic [HADDR_W-1:0] h_haddr;

  assign new_xfer   = M_HSEL & M_HTRANS[1] & M_HREADY;
  assign hold_valid = (state == ST_WAIT);
  // A new address phase can only begin when no data phase is stalling.
  assign can_start  = (state == ST_IDLE) | ((state == ST_DATA) & S_HREADY);
  assign hold_load  = can_start & new_xfer & ~ARB_REQ_ACK;

  ahb_addr_hold #(
    .HADDR_W (HADDR_W)
  ) u_hold (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .load        (hold_load),
    .d_htrans    (M_HTRANS),
    .d_hwrite    (M_HWRITE),
    .d_hsize     (M_HSIZE),
    .d_hburst    (M_HBURST),
    .d_hprot     (M_HPROT),
    .d_hmastlock (M_HMASTLOCK),
    .d_haddr     (M_HADDR),
    .q_htrans    (h_htrans),
    .q_hwrite    (h_hwrite),
    .q_hsize     (h_hsize),
    .q_hburst    (h_hburst),
    .q_hprot     (h_hprot),
    .q_hmastlock (h_hmastlock),
    .q_haddr     (h_haddr)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT: begin
        if (ARB_REQ_ACK) state_next = ST_DATA;
      end
      default: begin
        if (can_start) begin
          if (new_xfer) state_next = ARB_REQ_ACK ? ST_DATA : ST_WAIT;
          else          state_next = ST_IDLE;
        end
      end
    endcase
  end

  // Request and lock stay combinational so an idle arbiter grants without
  // an extra cycle; reset masks the request even before the state clears.
  assign ARB_REQ           = ~HRESET & (hold_valid | new_xfer);
  assign ARB_PRIORITY_LOCK = S_HMASTLOCK & ARB_REQ;

  // Address mux is deliberately not gated by ARB_REQ_ACK: the grant depends
  // on ARB_REQ, so gating would close a combinational loop.
  always_comb begin
    S_HTRANS    = M_HTRANS;
    S_HWRITE    = M_HWRITE;
    S_HSIZE     = M_HSIZE;
    S_HBURST    = M_HBURST;
    S_HPROT     = M_HPROT;
    S_HMASTLOCK = M_HMASTLOCK;
    S_HADDR     = M_HADDR;
    if (hold_valid) begin
      S_HTRANS    = h_htrans;
      S_HWRITE    = h_hwrite;
      S_HSIZE     = h_hsize;
      S_HBURST    = h_hburst;
      S_HPROT     = h_hprot;
      S_HMASTLOCK = h_hmastlock;
      S_HADDR     = h_haddr;
    end
  end

  assign S_HWDATA = M_HWDATA;

  always_comb begin
    M_HREADYOUT = 1'b1;
    M_HRESP     = HRESP_OKAY;
    M_HRDATA    = '0;
    case (state)
      ST_WAIT: M_HREADYOUT = 1'b0;
      ST_DATA: begin
        M_HREADYOUT = S_HREADY;
        M_HRESP     = S_HRESP;
        M_HRDATA    = S_HRDATA;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_mst_port.sv
// tb/tb_ahb_mst_port.sv - directed scoreboard bench for ahb_mst_port
module tb_ahb_mst_port;
  import ahb_pkg::*;

  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR4  = 3'b011;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        M_HSEL;
  logic [1:0]  M_HTRANS;
  logic        M_HWRITE;
  logic [2:0]  M_HSIZE;
  logic [2:0]  M_HBURST;
  logic [3:0]  M_HPROT;
  logic        M_HMASTLOCK;
  logic [31:0] M_HADDR;
  logic [31:0] M_HWDATA;
  logic        M_HREADY;
  logic        M_HREADYOUT;
  logic [31:0] M_HRDATA;
  logic        M_HRESP;
  logic        ARB_REQ;
  logic        ARB_REQ_ACK;
  logic        ARB_PRIORITY_LOCK;
  logic [1:0]  S_HTRANS;
  logic        S_HWRITE;
  logic [2:0]  S_HSIZE;
  logic [2:0]  S_HBURST;
  logic [3:0]  S_HPROT;
  logic        S_HMASTLOCK;
  logic [31:0] S_HADDR;
  logic [31:0] S_HWDATA;
  logic        S_HREADY;
  logic [31:0] S_HRDATA;
  logic        S_HRESP;

  logic ack_tie;
  logic ack_drv;

  // Single-master system: the master sees its own port's HREADYOUT.
  assign M_HREADY    = M_HREADYOUT;
  assign ARB_REQ_ACK = ack_tie ? ARB_REQ : ack_drv;

  always #5 HCLK = ~HCLK;

  ahb_mst_port #(.HADDR_W(32), .HDATA_W(32)) dut (
    .HCLK              (HCLK),
    .HRESET            (HRESET),
    .M_HSEL            (M_HSEL),
    .M_HTRANS          (M_HTRANS),
    .M_HWRITE          (M_HWRITE),
    .M_HSIZE           (M_HSIZE),
    .M_HBURST          (M_HBURST),
    .M_HPROT           (M_HPROT),
    .M_HMASTLOCK       (M_HMASTLOCK),
    .M_HADDR           (M_HADDR),
    .M_HWDATA          (M_HWDATA),
    .M_HREADY          (M_HREADY),
    .M_HREADYOUT       (M_HREADYOUT),
    .M_HRDATA          (M_HRDATA),
    .M_HRESP           (M_HRESP),
    .ARB_REQ           (ARB_REQ),
    .ARB_REQ_ACK       (ARB_REQ_ACK),
    .ARB_PRIORITY_LOCK (ARB_PRIORITY_LOCK),
    .S_HTRANS          (S_HTRANS),
    .S_HWRITE          (S_HWRITE),
    .S_HSIZE           (S_HSIZE),
    .S_HBURST          (S_HBURST),
    .S_HPROT           (S_HPROT),
    .S_HMASTLOCK       (S_HMASTLOCK),
    .S_HADDR           (S_HADDR),
    .S_HWDATA          (S_HWDATA),
    .S_HREADY          (S_HREADY),
    .S_HRDATA          (S_HRDATA),
    .S_HRESP           (S_HRESP)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic mdrive(input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [2:0] burst, input logic lock,
                        input logic [31:0] addr);
    M_HSEL      = sel;
    M_HTRANS    = tr;
    M_HWRITE    = wr;
    M_HSIZE     = 3'b010;
    M_HBURST    = burst;
    M_HPROT     = 4'b0011;
    M_HMASTLOCK = lock;
    M_HADDR     = addr;
  endtask

  task automatic midle();
    mdrive(1'b0, HTRANS_IDLE, 1'b0, BURST_SINGLE, 1'b0, 32'h0);
  endtask

  task automatic at_neg();
    @(negedge HCLK);
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET   = 1'b1;
    ack_tie  = 1'b1;
    ack_drv  = 1'b0;
    S_HREADY = 1'b1;
    S_HRESP  = 1'b0;
    S_HRDATA = 32'h0;
    M_HWDATA = 32'h0;
    midle();

    // Reset values, and request masked while reset is held.
    push_exp("rst_hreadyout", 32'd1);
    push_exp("rst_hresp", 32'd0);
    push_exp("rst_hrdata", 32'd0);
    push_exp("rst_arb_req", 32'd0);
    at_neg();
    check(M_HREADYOUT); check(M_HRESP); check(M_HRDATA); check(ARB_REQ);
    mdrive(1'b1, HTRANS_NONSEQ, 1'b1, BURST_SINGLE, 1'b1, 32'h1000);
    #1;
    push_exp("rst_req_masked", 32'd0);
    push_exp("rst_lock_masked", 32'd0);
    check(ARB_REQ); check(ARB_PRIORITY_LOCK);
    next_cycle();
    HRESET = 1'b0;
    midle();

    // BUSY never requests and gets a zero-wait OKAY.
    mdrive(1'b1, HTRANS_BUSY, 1'b0, HBURST_INCR, 1'b0, 32'h1100);
    push_exp("busy_req", 32'd0);
    push_exp("busy_ready", 32'd1);
    at_neg();
    check(ARB_REQ); check(M_HREADYOUT);
    next_cycle();

    // Uncontested write: same-cycle issue, zero wait states.
    mdrive(1'b1, HTRANS_NONSEQ, 1'b1, BURST_SINGLE, 1'b0, 32'h1000);
    S_HREADY = 1'b1;
    push_exp("uw_req", 32'd1);
    push_exp("uw_haddr", 32'h1000);
    push_exp("uw_hwrite", 32'd1);
    push_exp("uw_htrans", 32'(HTRANS_NONSEQ));
    push_exp("uw_ready", 32'd1);
    at_neg();
    check(ARB_REQ); check(S_HADDR); check(S_HWRITE); check(S_HTRANS); check(M_HREADYOUT);
    next_cycle();
    midle();
    M_HWDATA = 32'h11112222;
    S_HREADY = 1'b0;
    push_exp("uw_hwdata", 32'h11112222);
    push_exp("uw_stall_ready", 32'd0);
    at_neg();
    check(S_HWDATA); check(M_HREADYOUT);
    next_cycle();
    S_HREADY = 1'b1;
    push_exp("uw_done_ready", 32'd1);
    at_neg();
    check(M_HREADYOUT);
    next_cycle();
    S_HREADY = 1'b0;
    push_exp("idle_ignores_shready", 32'd1);
    at_neg();
    check(M_HREADYOUT);
    next_cycle();
    S_HREADY = 1'b1;

    // Contested read: three wait states with the address held stable.
    ack_tie = 1'b0;
    ack_drv = 1'b0;
    rd_q.push_back(32'hCAFEF00D);
    mdrive(1'b1, HTRANS_NONSEQ, 1'b0, BURST_SINGLE, 1'b0, 32'h2000);
    push_exp("cr_req", 32'd1);
    at_neg();
    check(ARB_REQ);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      M_HADDR = 32'hDEAD0000;
      ack_drv = (i == 2);
      push_exp("cr_wait_ready", 32'd0);
      push_exp("cr_held_haddr", 32'h2000);
      push_exp("cr_wait_req", 32'd1);
      at_neg();
      check(M_HREADYOUT); check(S_HADDR); check(ARB_REQ);
      next_cycle();
    end
    midle();
    ack_drv  = 1'b0;
    S_HREADY = 1'b1;
    S_HRDATA = 32'hCAFEF00D;
    push_exp("cr_data_ready", 32'd1);
    push_exp("cr_hrdata", rd_q.pop_front());
    at_neg();
    check(M_HREADYOUT); check(M_HRDATA);
    next_cycle();
    S_HRDATA = 32'h0;

    // Burst split: beat 3 blocked, reissued as NONSEQ/INCR.
    ack_tie = 1'b1;
    mdrive(1'b1, HTRANS_NONSEQ, 1'b1, BURST_INCR4, 1'b0, 32'h3000);
    push_exp("bs1_haddr", 32'h3000);
    at_neg();
    check(S_HADDR);
    next_cycle();
    mdrive(1'b1, HTRANS_SEQ, 1'b1, BURST_INCR4, 1'b0, 32'h3004);
    push_exp("bs2_haddr", 32'h3004);
    push_exp("bs2_htrans", 32'(HTRANS_SEQ));
    at_neg();
    check(S_HADDR); check(S_HTRANS);
    next_cycle();
    mdrive(1'b1, HTRANS_SEQ, 1'b1, BURST_INCR4, 1'b0, 32'h3008);
    ack_tie = 1'b0;
    ack_drv = 1'b0;
    push_exp("bs3_req", 32'd1);
    at_neg();
    check(ARB_REQ);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      ack_drv = (i == 1);
      push_exp("bs_wait_htrans", 32'(HTRANS_NONSEQ));
      push_exp("bs_wait_hburst", 32'(HBURST_INCR));
      push_exp("bs_wait_haddr", 32'h3008);
      push_exp("bs_wait_ready", 32'd0);
      at_neg();
      check(S_HTRANS); check(S_HBURST); check(S_HADDR); check(M_HREADYOUT);
      next_cycle();
    end
    ack_tie = 1'b1;
    ack_drv = 1'b0;
    mdrive(1'b1, HTRANS_SEQ, 1'b1, BURST_INCR4, 1'b0, 32'h300C);
    S_HREADY = 1'b1;
    push_exp("bs4_haddr", 32'h300C);
    push_exp("bs4_htrans", 32'(HTRANS_SEQ));
    push_exp("bs4_hburst", 32'(BURST_INCR4));
    push_exp("bs4_ready", 32'd1);
    at_neg();
    check(S_HADDR); check(S_HTRANS); check(S_HBURST); check(M_HREADYOUT);
    next_cycle();
    midle();
    next_cycle();

    // Two-cycle ERROR passes through, then IDLE returns to ST_IDLE.
    mdrive(1'b1, HTRANS_NONSEQ, 1'b0, BURST_SINGLE, 1'b0, 32'h4000);
    next_cycle();
    midle();
    S_HREADY = 1'b0;
    S_HRESP  = 1'b1;
    push_exp("err1_ready", 32'd0);
    push_exp("err1_resp", 32'd1);
    at_neg();
    check(M_HREADYOUT); check(M_HRESP);
    next_cycle();
    S_HREADY = 1'b1;
    push_exp("err2_ready", 32'd1);
    push_exp("err2_resp", 32'd1);
    at_neg();
    check(M_HREADYOUT); check(M_HRESP);
    next_cycle();
    S_HREADY = 1'b0;
    push_exp("err_after_ready", 32'd1);
    push_exp("err_after_resp", 32'd0);
    at_neg();
    check(M_HREADYOUT); check(M_HRESP);
    next_cycle();
    S_HREADY = 1'b1;
    S_HRESP  = 1'b0;

    // Locked transfer: lock follows the request exactly.
    mdrive(1'b1, HTRANS_NONSEQ, 1'b1, BURST_SINGLE, 1'b1, 32'h5000);
    push_exp("lk_req", 32'd1);
    push_exp("lk_lock", 32'd1);
    at_neg();
    check(ARB_REQ); check(ARB_PRIORITY_LOCK);
    next_cycle();
    mdrive(1'b0, HTRANS_IDLE, 1'b0, BURST_SINGLE, 1'b1, 32'h5000);
    push_exp("lk_after_req", 32'd0);
    push_exp("lk_after_lock", 32'd0);
    at_neg();
    check(ARB_REQ); check(ARB_PRIORITY_LOCK);
    next_cycle();
    midle();

    // Reset pulsed in ST_WAIT drops the held transfer immediately.
    ack_tie = 1'b0;
    ack_drv = 1'b0;
    mdrive(1'b1, HTRANS_NONSEQ, 1'b1, BURST_SINGLE, 1'b0, 32'h6000);
    next_cycle();
    push_exp("rw_req", 32'd1);
    push_exp("rw_ready", 32'd0);
    at_neg();
    check(ARB_REQ); check(M_HREADYOUT);
    #2;
    HRESET = 1'b1;
    #1;
    push_exp("rw_async_req", 32'd0);
    push_exp("rw_async_ready", 32'd1);
    check(ARB_REQ); check(M_HREADYOUT);
    next_cycle();
    HRESET  = 1'b0;
    midle();
    ack_drv = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_exp("post_rst_req", 32'd0);
      push_exp("post_rst_htrans", 32'(HTRANS_IDLE));
      push_exp("post_rst_ready", 32'd1);
      at_neg();
      check(ARB_REQ); check(S_HTRANS); check(M_HREADYOUT);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
